// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - shared state, ASCII and rate definitions for the command parser
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG_R,
    ST_ARG_D,
    ST_WAIT_CR,
    ST_COMMIT,
    ST_ERR
  } stateT;

  typedef logic [1:0] rateT;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_R      = 8'h52;
  localparam logic [7:0] ASCII_D      = 8'h44;
  localparam logic [7:0] ASCII_G      = 8'h47;
  localparam logic [7:0] ASCII_H      = 8'h48;
  localparam logic [7:0] ASCII_T      = 8'h54;
  localparam logic [7:0] ASCII_K      = 8'h4B;
  localparam logic [7:0] ASCII_E      = 8'h45;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;

  function automatic logic isDigit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_digit_buf.sv
// rtl/uart_cmd_parser_digit_buf.sv - cmd_digit_buf: payload digit store with count and read index
module cmd_digit_buf #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wrEn,
  input  logic [7:0]    wrData,
  input  logic          rdAdv,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          rdLast,
  output logic [7:0]    rdData
);

  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] rdIdx;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      rdIdx <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wrEn && !full) begin
        mem[count[IW-1:0]] <= wrData;
        count              <= count + CW'(1);
      end
      if (rdAdv) rdIdx <= rdIdx + CW'(1);
    end
  end

  assign full   = (count == CW'(DEPTH));
  assign rdLast = ((rdIdx + CW'(1)) == count);
  assign rdData = mem[rdIdx[IW-1:0]];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed ASCII command parser with timeout; UART_CMD_ECHO_EN adds K/E ack echo
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int MAX_DIGITS  = 8,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  input  logic       iFIFO_FULL,
  output logic [7:0] oData,
  output logic       oWRen,
  output logic [1:0] oRate,
  output logic       oSTART,
  output logic       oTX_REQ,
  output logic       oERR,
  output logic       oDROP,
  output logic       oBUSY
`ifdef UART_CMD_ECHO_EN
  ,
  output logic [7:0] oACK_DATA,
  output logic       oACK_VALID
`endif
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  stateT         state, stateNext;
  logic [TW-1:0] tmoCnt;
  logic [7:0]    cmdReg;
  rateT          pendRate;
  logic [CW-1:0] bufCount;
  logic          bufFull, bufLast, bufClr, bufWr, bufAdv;
  logic          timed, expire, errSet, execSet, cmdLoad, pendLoad;

  cmd_digit_buf #(.DEPTH(MAX_DIGITS)) uDigitBuf (
    .clk    (clk),
    .reset  (reset),
    .clr    (bufClr),
    .wrEn   (bufWr),
    .wrData (iRX_DATA),
    .rdAdv  (bufAdv),
    .count  (bufCount),
    .full   (bufFull),
    .rdLast (bufLast),
    .rdData (oData)
  );

  assign timed  = state inside {ST_CMD, ST_ARG_R, ST_ARG_D, ST_WAIT_CR, ST_ERR};
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign expire = timed && !iRX_VALID && (tmoCnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    bufClr    = 1'b0;
    bufWr     = 1'b0;
    bufAdv    = 1'b0;
    errSet    = 1'b0;
    execSet   = 1'b0;
    cmdLoad   = 1'b0;
    pendLoad  = 1'b0;
    if (expire) begin
      stateNext = ST_IDLE;
      bufClr    = 1'b1;
      errSet    = (state != ST_ERR);
    end else begin
      case (state)
        ST_IDLE: if (iRX_VALID && iRX_DATA == ASCII_DOLLAR) stateNext = ST_CMD;
        ST_CMD: if (iRX_VALID) begin
          case (iRX_DATA)
            ASCII_R: begin
              stateNext = ST_ARG_R;
              cmdLoad   = 1'b1;
            end
            ASCII_D: begin
              stateNext = ST_ARG_D;
              bufClr    = 1'b1;
            end
            ASCII_G, ASCII_H, ASCII_T: begin
              stateNext = ST_WAIT_CR;
              cmdLoad   = 1'b1;
            end
            default: stateNext = ST_ERR;
          endcase
        end
        ST_ARG_R: if (iRX_VALID) begin
          if (iRX_DATA >= ASCII_0 && iRX_DATA <= ASCII_0 + 8'd3) begin
            stateNext = ST_WAIT_CR;
            pendLoad  = 1'b1;
          end else begin
            stateNext = ST_ERR;
          end
        end
        ST_ARG_D: if (iRX_VALID) begin
          if (isDigit(iRX_DATA) && !bufFull)            bufWr     = 1'b1;
          else if (iRX_DATA == ASCII_CR && bufCount != '0) stateNext = ST_COMMIT;
          else                                          stateNext = ST_ERR;
        end
        ST_WAIT_CR: if (iRX_VALID) begin
          if (iRX_DATA == ASCII_CR) begin
            stateNext = ST_IDLE;
            execSet   = 1'b1;
          end else begin
            stateNext = ST_ERR;
          end
        end
        ST_COMMIT: if (!iFIFO_FULL) begin
          bufAdv = 1'b1;
          if (bufLast) begin
            stateNext = ST_IDLE;
            bufClr    = 1'b1;
          end
        end
        ST_ERR: if (iRX_VALID) begin
          if (iRX_DATA == ASCII_DOLLAR)  stateNext = ST_CMD;
          else if (iRX_DATA == ASCII_CR) stateNext = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
      if (stateNext == ST_ERR && state != ST_ERR) begin
        errSet = 1'b1;
        bufClr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmoCnt   <= '0;
      cmdReg   <= '0;
      pendRate <= '0;
      oRate    <= '0;
      oSTART   <= 1'b0;
      oTX_REQ  <= 1'b0;
      oERR     <= 1'b0;
      oDROP    <= 1'b0;
    end else begin
      if (!timed || iRX_VALID || expire) tmoCnt <= '0;
      else                               tmoCnt <= tmoCnt + TW'(1);
      if (cmdLoad)  cmdReg   <= iRX_DATA;
      if (pendLoad) pendRate <= rateT'(iRX_DATA[1:0]);
      if (execSet) begin
        case (cmdReg)
          ASCII_R: oRate  <= pendRate;
          ASCII_G: oSTART <= 1'b1;
          ASCII_H: oSTART <= 1'b0;
          default: ;
        endcase
      end
      oTX_REQ <= execSet && (cmdReg == ASCII_T);
      oERR    <= errSet;
      oDROP   <= (state == ST_COMMIT) && iRX_VALID;
    end
  end

`ifdef UART_CMD_ECHO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      oACK_VALID <= 1'b0;
      oACK_DATA  <= '0;
    end else if (execSet || (state == ST_COMMIT && stateNext == ST_IDLE)) begin
      oACK_VALID <= 1'b1;
      oACK_DATA  <= ASCII_K;
    end else if (errSet || expire) begin
      oACK_VALID <= 1'b1;
      oACK_DATA  <= ASCII_E;
    end else begin
      oACK_VALID <= 1'b0;
      oACK_DATA  <= '0;
    end
  end
`endif

  // Write strobe follows the live FIFO flag so a full FIFO never sees a write.
  assign oWRen = (state == ST_COMMIT) && !iFIFO_FULL && !reset;
  assign oBUSY = (state != ST_IDLE);

endmodule
